// File: rtl/mem_read_arbiter.sv
// Two-port (instruction/data) read arbiter in front of a single synchronous memory read port.
// Grants one requester, strobes memory, waits MEM_LATENCY cycles, returns data with a done pulse.
module mem_read_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1,  // legal range 1..15
  parameter int D_PRIORITY  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STRB,
    S_WAIT
  } state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  port_e               owner_q, owner_d;
  port_e               last_q, last_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rstrb_q, mem_rstrb_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic                busy_q, busy_d;
  port_e               winner;

  // Tie-break: data-priority mode always picks D; otherwise the port not granted last wins.
  always_comb begin
    winner = PORT_I;
    if (i_req && d_req) begin
      if (D_PRIORITY != 0) begin
        winner = PORT_D;
      end else begin
        winner = (last_q == PORT_D) ? PORT_I : PORT_D;
      end
    end else if (d_req) begin
      winner = PORT_D;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_rstrb_d = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          mem_addr_d  = (winner == PORT_D) ? d_addr : i_addr;
          mem_rstrb_d = 1'b1;
          owner_d     = winner;
          last_d      = winner;
          cnt_d       = CNT_INIT;
          busy_d      = 1'b1;
          state_d     = S_STRB;
        end
      end
      S_STRB: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q == PORT_D) begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= PORT_I;
      last_q      <= PORT_D;
      mem_addr_q  <= '0;
      mem_rstrb_q <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_rstrb_q <= mem_rstrb_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rstrb = mem_rstrb_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: three instances (L=1 round-robin, L=3 round-robin, L=1 data-priority)
// sharing stimulus, each with its own latency-accurate memory model.
module tb_mem_read_arbiter;

  localparam logic [31:0] M3  = 32'h0010_0093;
  localparam logic [31:0] M4  = 32'hC0DE_0004;
  localparam logic [31:0] M7  = 32'hC0DE_0007;
  localparam logic [31:0] M9  = 32'hC0DE_0009;
  localparam logic [31:0] M10 = 32'hC0DE_000A;
  localparam int LAT [3] = '{1, 3, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = 32'd0;

  logic [31:0] i_rdata   [3];
  logic        i_done    [3];
  logic [31:0] d_rdata   [3];
  logic        d_done    [3];
  logic        busy      [3];
  logic [31:0] mem_addr  [3];
  logic        mem_rstrb [3];
  logic [31:0] mem_rdata [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_W(32), .MEM_LATENCY(1), .D_PRIORITY(0)) u_rr1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata[0]), .i_done(i_done[0]),
    .d_req(d_req), .d_addr(d_addr), .d_rdata(d_rdata[0]), .d_done(d_done[0]),
    .busy(busy[0]), .mem_addr(mem_addr[0]), .mem_rstrb(mem_rstrb[0]), .mem_rdata(mem_rdata[0])
  );

  mem_read_arbiter #(.ADDR_W(32), .MEM_LATENCY(3), .D_PRIORITY(0)) u_rr3 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata[1]), .i_done(i_done[1]),
    .d_req(d_req), .d_addr(d_addr), .d_rdata(d_rdata[1]), .d_done(d_done[1]),
    .busy(busy[1]), .mem_addr(mem_addr[1]), .mem_rstrb(mem_rstrb[1]), .mem_rdata(mem_rdata[1])
  );

  mem_read_arbiter #(.ADDR_W(32), .MEM_LATENCY(1), .D_PRIORITY(1)) u_dp1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata[2]), .i_done(i_done[2]),
    .d_req(d_req), .d_addr(d_addr), .d_rdata(d_rdata[2]), .d_done(d_done[2]),
    .busy(busy[2]), .mem_addr(mem_addr[2]), .mem_rstrb(mem_rstrb[2]), .mem_rdata(mem_rdata[2])
  );

  // Memory model: data valid only in cycle strobe+LAT, garbage otherwise.
  logic [31:0] mem [64];
  logic [3:0]  rdy [3];

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 | 32'(k);
    mem[3] = M3;
  end

  always @(posedge clk or posedge reset) begin
    for (int n = 0; n < 3; n++) begin
      if (reset) rdy[n] <= 4'd0;
      else if (mem_rstrb[n]) rdy[n] <= 4'(LAT[n]);
      else if (rdy[n] != 4'd0) rdy[n] <= rdy[n] - 4'd1;
    end
  end

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      mem_rdata[n] = (rdy[n] == 4'd1) ? mem[mem_addr[n][7:2]] : 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, then wait to the falling edge for sampling.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da);
    @(posedge clk);
    #1;
    reset  = rst;
    i_req  = ir;
    i_addr = ia;
    d_req  = dr;
    d_addr = da;
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        e_rstrb;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_i_done;
    logic [31:0] e_i_rdata;
    logic        e_d_done;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int d_cnt;
    logic [6:0] exp_busy, exp_done, exp_strb;

    // Single fetch, then reset, then a round-robin tie with both requests held (u_rr1).
    //            rst ireq iaddr     dreq daddr    | strb addr      busy idone irdata dd  drdata
    vecs[0]  = '{0, 1, 32'h0C, 0, 32'h00, 0, 32'h00, 0, 0, 32'h0, 0, 32'h0};
    vecs[1]  = '{0, 1, 32'h0C, 0, 32'h00, 1, 32'h0C, 1, 0, 32'h0, 0, 32'h0};
    vecs[2]  = '{0, 1, 32'h0C, 0, 32'h00, 0, 32'h0C, 1, 0, 32'h0, 0, 32'h0};
    vecs[3]  = '{0, 0, 32'h0C, 0, 32'h00, 0, 32'h0C, 0, 1, M3,    0, 32'h0};
    vecs[4]  = '{0, 0, 32'h0C, 0, 32'h00, 0, 32'h0C, 0, 0, M3,    0, 32'h0};
    vecs[5]  = '{1, 0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 0, 32'h0, 0, 32'h0};
    vecs[6]  = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h00, 0, 0, 32'h0, 0, 32'h0};
    vecs[7]  = '{0, 1, 32'h10, 1, 32'h24, 1, 32'h10, 1, 0, 32'h0, 0, 32'h0};
    vecs[8]  = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h10, 1, 0, 32'h0, 0, 32'h0};
    vecs[9]  = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h10, 0, 1, M4,    0, 32'h0};
    vecs[10] = '{0, 1, 32'h10, 1, 32'h24, 1, 32'h24, 1, 0, M4,    0, 32'h0};
    vecs[11] = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h24, 1, 0, M4,    0, 32'h0};
    vecs[12] = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h24, 0, 0, M4,    1, M9};
    vecs[13] = '{0, 1, 32'h10, 1, 32'h24, 1, 32'h10, 1, 0, M4,    0, M9};
    vecs[14] = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h10, 1, 0, M4,    0, M9};
    vecs[15] = '{0, 1, 32'h10, 1, 32'h24, 0, 32'h10, 0, 1, M4,    0, M9};
    vecs[16] = '{0, 0, 32'h10, 0, 32'h24, 1, 32'h24, 1, 0, M4,    0, M9};
    vecs[17] = '{0, 0, 32'h10, 0, 32'h24, 0, 32'h24, 1, 0, M4,    0, M9};
    vecs[18] = '{0, 0, 32'h10, 0, 32'h24, 0, 32'h24, 0, 0, M4,    1, M9};
    vecs[19] = '{0, 0, 32'h10, 0, 32'h24, 0, 32'h24, 0, 0, M4,    0, M9};

    for (int v = 0; v < 20; v++) begin
      step(vecs[v].rst, vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req, vecs[v].d_addr);
      check($sformatf("vec%0d mem_rstrb", v), 32'(mem_rstrb[0]), 32'(vecs[v].e_rstrb));
      check($sformatf("vec%0d mem_addr", v), mem_addr[0], vecs[v].e_addr);
      check($sformatf("vec%0d busy", v), 32'(busy[0]), 32'(vecs[v].e_busy));
      check($sformatf("vec%0d i_done", v), 32'(i_done[0]), 32'(vecs[v].e_i_done));
      check($sformatf("vec%0d i_rdata", v), i_rdata[0], vecs[v].e_i_rdata);
      check($sformatf("vec%0d d_done", v), 32'(d_done[0]), 32'(vecs[v].e_d_done));
      check($sformatf("vec%0d d_rdata", v), d_rdata[0], vecs[v].e_d_rdata);
    end

    // Data priority: both held, D wins every arbitration (u_dp1).
    step(1, 0, 32'h0, 0, 32'h0);
    d_cnt = 0;
    for (int c = 0; c <= 12; c++) begin
      step(0, 1, 32'h0C, 1, 32'h28);
      check($sformatf("dprio c%0d i_done", c), 32'(i_done[2]), 32'd0);
      if (mem_rstrb[2]) check($sformatf("dprio c%0d mem_addr", c), mem_addr[2], 32'h28);
      if (d_done[2]) d_cnt++;
    end
    check("dprio d_done count", 32'(d_cnt), 32'd4);
    check("dprio d_rdata", d_rdata[2], M10);
    check("dprio i_rdata untouched", i_rdata[2], 32'd0);

    // Latency 3: strobe C1, busy C1..C4, done C5 (u_rr3).
    step(1, 0, 32'h0, 0, 32'h0);
    exp_busy = 7'b0011110;
    exp_done = 7'b0100000;
    exp_strb = 7'b0000010;
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 32'h0, (c < 5), 32'h1C);
      check($sformatf("lat3 c%0d busy", c), 32'(busy[1]), 32'(exp_busy[c]));
      check($sformatf("lat3 c%0d d_done", c), 32'(d_done[1]), 32'(exp_done[c]));
      check($sformatf("lat3 c%0d mem_rstrb", c), 32'(mem_rstrb[1]), 32'(exp_strb[c]));
      if (c == 5) check("lat3 d_rdata", d_rdata[1], M7);
    end

    // Reset in the WAIT cycle: outputs clear at once, aborted access never completes (u_rr1).
    step(1, 0, 32'h0, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'h20);
    step(0, 0, 32'h0, 1, 32'h20);
    check("rst strobe before abort", 32'(mem_rstrb[0]), 32'd1);
    step(1, 0, 32'h0, 0, 32'h0);
    check("rst mem_addr", mem_addr[0], 32'd0);
    check("rst busy", 32'(busy[0]), 32'd0);
    check("rst i_rdata", i_rdata[0], 32'd0);
    check("rst d_rdata", d_rdata[0], 32'd0);
    check("rst mem_rstrb", 32'(mem_rstrb[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 32'h0, 0, 32'h0);
      check($sformatf("rst post c%0d d_done", c), 32'(d_done[0]), 32'd0);
      check($sformatf("rst post c%0d busy", c), 32'(busy[0]), 32'd0);
    end
    step(0, 1, 32'h0C, 0, 32'h0);
    step(0, 1, 32'h0C, 0, 32'h0);
    step(0, 1, 32'h0C, 0, 32'h0);
    step(0, 0, 32'h0C, 0, 32'h0);
    check("rst next i_done", 32'(i_done[0]), 32'd1);
    check("rst next i_rdata", i_rdata[0], M3);

    // Address change after grant, plus a D request dropped before it could be granted (u_rr1).
    step(1, 0, 32'h0, 0, 32'h0);
    step(0, 1, 32'h10, 0, 32'h0);
    step(0, 1, 32'h20, 1, 32'h30);
    check("achg C1 mem_addr", mem_addr[0], 32'h10);
    check("achg C1 mem_rstrb", 32'(mem_rstrb[0]), 32'd1);
    step(0, 1, 32'h20, 0, 32'h0);
    check("achg C2 mem_addr", mem_addr[0], 32'h10);
    step(0, 0, 32'h20, 0, 32'h0);
    check("achg i_done", 32'(i_done[0]), 32'd1);
    check("achg i_rdata", i_rdata[0], M4);
    check("achg d_done", 32'(d_done[0]), 32'd0);
    for (int c = 0; c < 2; c++) begin
      step(0, 0, 32'h0, 0, 32'h0);
      check($sformatf("cancel c%0d busy", c), 32'(busy[0]), 32'd0);
      check($sformatf("cancel c%0d mem_rstrb", c), 32'(mem_rstrb[0]), 32'd0);
      check($sformatf("cancel c%0d d_done", c), 32'(d_done[0]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
